// File: rtl/branch_predictor.sv
// Fetch-stage BTB + 2-bit PHT predictor with mispredict counter.
// Define BP_GSHARE_EN to hash the PHT index with a global history register.
module branch_predictor #(
  parameter int IDX_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [31:0]      fetch_pc,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  input  logic [31:0]      upd_target,
  input  logic             upd_pred_taken,
  output logic             mispredict,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int N     = 1 << IDX_W;
  localparam int TAG_W = 30 - IDX_W;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
  } btb_t;

  btb_t       btb [N];
  logic [1:0] ctr [N];

  logic [IDX_W-1:0] f_idx;
  logic [IDX_W-1:0] u_idx;
  logic [IDX_W-1:0] f_cidx;
  logic [IDX_W-1:0] u_cidx;
  logic [TAG_W-1:0] f_tag;
  logic [TAG_W-1:0] u_tag;
  logic             f_hit;
  logic             u_hit;
  logic [1:0]       u_ctr;

  logic       btb_wr;
  btb_t       btb_nxt;
  logic       ctr_wr;
  logic [1:0] ctr_nxt;

  logic unused_pc_lsb;
  assign unused_pc_lsb = ^{fetch_pc[1:0], upd_pc[1:0]};

  assign f_idx = fetch_pc[IDX_W+1:2];
  assign u_idx = upd_pc[IDX_W+1:2];
  assign f_tag = fetch_pc[31:IDX_W+2];
  assign u_tag = upd_pc[31:IDX_W+2];

`ifdef BP_GSHARE_EN
  logic [IDX_W-1:0] ghr;
  assign f_cidx = f_idx ^ ghr;
  assign u_cidx = u_idx ^ ghr;
`else
  assign f_cidx = f_idx;
  assign u_cidx = u_idx;
`endif

  assign f_hit = btb[f_idx].valid
               && (btb[f_idx].tag == f_tag);
  assign u_hit = btb[u_idx].valid
               && (btb[u_idx].tag == u_tag);
  assign u_ctr = ctr[u_cidx];

  assign pred_taken  = f_hit & ctr[f_cidx][1];
  assign pred_target = pred_taken
                     ? btb[f_idx].target : '0;

  assign mispredict = upd_valid
                    & (upd_taken ^ upd_pred_taken);

  always_comb begin
    btb_wr  = 1'b0;
    btb_nxt = btb[u_idx];
    ctr_wr  = 1'b0;
    ctr_nxt = u_ctr;
    if (upd_valid) begin
      unique case (1'b1)
        u_hit: begin
          ctr_wr = 1'b1;
          if (upd_taken) begin
            ctr_nxt = (u_ctr == 2'd3)
                    ? u_ctr : u_ctr + 2'd1;
            btb_wr         = 1'b1;
            btb_nxt.target = upd_target;
          end else begin
            ctr_nxt = (u_ctr == 2'd0)
                    ? u_ctr : u_ctr - 2'd1;
          end
        end
        (!u_hit && upd_taken): begin
          btb_wr         = 1'b1;
          btb_nxt.valid  = 1'b1;
          btb_nxt.tag    = u_tag;
          btb_nxt.target = upd_target;
          ctr_wr         = 1'b1;
          ctr_nxt        = 2'b10;
        end
        default: ;
      endcase
    end
  end

  // Tags and targets are left unreset; valid gates them.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < N; i++) begin
        btb[i].valid <= 1'b0;
        ctr[i]       <= 2'b01;
      end
      mispredict_cnt <= '0;
`ifdef BP_GSHARE_EN
      ghr <= '0;
`endif
    end else begin
      if (btb_wr)
        btb[u_idx] <= btb_nxt;
      if (ctr_wr)
        ctr[u_cidx] <= ctr_nxt;
      if (mispredict && (mispredict_cnt != '1))
        mispredict_cnt <= mispredict_cnt
                        + CNT_W'(1);
`ifdef BP_GSHARE_EN
      if (upd_valid)
        ghr <= {ghr[IDX_W-2:0], upd_taken};
`endif
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor against a table-level model.
// Directed test-plan sequence followed by randomized traffic.
module tb_branch_predictor;

  localparam int IDX_W = 4;
  localparam int CNT_W = 3;
  localparam int N     = 1 << IDX_W;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             RST;
  logic [31:0]      fetch_pc;
  logic             pred_taken;
  logic [31:0]      pred_target;
  logic             upd_valid;
  logic [31:0]      upd_pc;
  logic             upd_taken;
  logic [31:0]      upd_target;
  logic             upd_pred_taken;
  logic             mispredict;
  logic [CNT_W-1:0] mispredict_cnt;

  always #5 CLK = ~CLK;

  branch_predictor #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK),
    .RST(RST),
    .fetch_pc(fetch_pc),
    .pred_taken(pred_taken),
    .pred_target(pred_target),
    .upd_valid(upd_valid),
    .upd_pc(upd_pc),
    .upd_taken(upd_taken),
    .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken),
    .mispredict(mispredict),
    .mispredict_cnt(mispredict_cnt)
  );

  typedef struct {
    string       name;
    bit          pt;
    logic [31:0] tgt;
    bit          mp;
    int          cnt;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: per-index BTB state plus counter table.
  bit          mv   [N];
  int unsigned mtag [N];
  logic [31:0] mtgt [N];
  int          mctr [N];
  int          mghr;
  int          mcnt;

  function automatic int bidx(input logic [31:0] pc);
    return int'((pc >> 2) % N);
  endfunction

  function automatic int cidx(input logic [31:0] pc);
    int i;
    i = bidx(pc);
`ifdef BP_GSHARE_EN
    i = i ^ mghr;
`endif
    return i;
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    int i;
    i = bidx(pc);
    return mv[i] && (mtag[i] == (pc >> (IDX_W + 2)));
  endfunction

  function automatic bit m_pred(input logic [31:0] pc);
    return m_hit(pc) && (mctr[cidx(pc)] >= 2);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      mv[i]   = 1'b0;
      mctr[i] = 1;
    end
    mghr = 0;
    mcnt = 0;
  endtask

  task automatic m_update(input logic [31:0] pc,
                          input bit t,
                          input logic [31:0] tgt);
    int i;
    int c;
    i = bidx(pc);
    c = cidx(pc);
    if (m_hit(pc)) begin
      if (t) begin
        if (mctr[c] < 3) mctr[c]++;
        mtgt[i] = tgt;
      end else if (mctr[c] > 0) begin
        mctr[c]--;
      end
    end else if (t) begin
      mv[i]   = 1'b1;
      mtag[i] = pc >> (IDX_W + 2);
      mtgt[i] = tgt;
      mctr[c] = 2;
    end
    mghr = ((mghr << 1) | int'(t)) % N;
  endtask

  task automatic step(input string nm,
                      input bit chk,
                      input bit rst,
                      input logic [31:0] fpc,
                      input bit uv,
                      input logic [31:0] upc,
                      input bit ut,
                      input logic [31:0] utgt,
                      input bit upt);
    exp_t e;
    RST            = rst;
    fetch_pc       = fpc;
    upd_valid      = uv;
    upd_pc         = upc;
    upd_taken      = ut;
    upd_target     = utgt;
    upd_pred_taken = upt;
    e.name = nm;
    e.pt   = m_pred(fpc);
    e.tgt  = e.pt ? mtgt[bidx(fpc)] : 32'h0;
    e.mp   = uv && (ut != upt);
    e.cnt  = mcnt;
    if (chk) sbq.push_back(e);
    @(posedge CLK);
    if (rst) begin
      m_reset();
    end else begin
      if (e.mp && mcnt < CMAX) mcnt++;
      if (uv) m_update(upc, ut, utgt);
    end
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk({e.name, ".pred_taken"}, 32'(pred_taken), 32'(e.pt));
      chk({e.name, ".pred_target"}, pred_target, e.tgt);
      chk({e.name, ".mispredict"}, 32'(mispredict), 32'(e.mp));
      chk({e.name, ".cnt"}, 32'(mispredict_cnt), 32'(e.cnt));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] fpc;
    logic [31:0] upc;
    logic [31:0] tgt;
    bit          uv;
    bit          ut;
    bit          upt;
    bit          rst;
    m_reset();
    step("rst0", 0, 1, 32'h40, 0, 0, 0, 0, 0);
    step("rst1", 0, 1, 32'h40, 0, 0, 0, 0, 0);
    step("reset", 1, 0, 32'h40, 0, 0, 0, 0, 0);
    step("alloc", 1, 0, 32'h0, 1, 32'h40, 1, 32'h80, 0);
    step("f_alloc", 1, 0, 32'h40, 0, 0, 0, 0, 0);
    step("nt1", 1, 0, 32'h0, 1, 32'h40, 0, 0, 1);
    step("f_nt1", 1, 0, 32'h40, 0, 0, 0, 0, 0);
    step("t1", 1, 0, 32'h0, 1, 32'h40, 1, 32'h80, 0);
    step("t2", 1, 0, 32'h0, 1, 32'h40, 1, 32'h80, 1);
    step("nt2", 1, 0, 32'h0, 1, 32'h40, 0, 0, 1);
    step("f_hyst", 1, 0, 32'h40, 0, 0, 0, 0, 0);
    step("alias", 1, 0, 32'h40, 1, 32'h440, 1, 32'h1234, 0);
    step("f_old", 1, 0, 32'h40, 0, 0, 0, 0, 0);
    step("f_new", 1, 0, 32'h440, 0, 0, 0, 0, 0);
    step("rst_upd", 1, 1, 32'h440, 1, 32'h80, 1, 32'h200, 0);
    step("post_rst", 1, 0, 32'h80, 0, 0, 0, 0, 0);
    step("same", 1, 0, 32'h40, 1, 32'h40, 1, 32'h100, 0);
    step("f_same", 1, 0, 32'h40, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++)
      step("sat", 1, 0, 32'h40, 1, 32'h800, 0, 0, 1);
    step("f_sat", 1, 0, 32'h40, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2000; i++) begin
      fpc = ($urandom_range(0, 3) << 6)
          | ($urandom_range(0, N - 1) << 2);
      upc = ($urandom_range(0, 3) << 6)
          | ($urandom_range(0, N - 1) << 2);
      tgt = $urandom & 32'hFFFF_FFFC;
      uv  = ($urandom_range(0, 9) < 6);
      ut  = $urandom_range(0, 1);
      upt = $urandom_range(0, 1) ? m_pred(upc)
                                 : 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 299) == 0);
      step("rand", 1, rst, fpc, uv, upc, ut, tgt, upt);
    end
    step("idle", 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    n_checks++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
